// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: VGA timing constants, counter widths
// and reader state shared by the VGA output slice.
package vga_timing_pkg;

  localparam int H_W = 11;
  localparam int V_W = 10;

  localparam int H_SYNC   = 96;
  localparam int H_START  = 216;
  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 1040;
  localparam int V_SYNC   = 2;
  localparam int V_START  = 35;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    RUN     = 2'd2
  } state_t;

endpackage

// File: rtl/vga_out_reader_if.sv
// vga_out_reader_if: read request and returned RGB
// between the VGA reader and the output line buffer.
interface vga_out_reader_if;
  logic       oRead_out_en;
  logic [7:0] R_in;
  logic [7:0] G_in;
  logic [7:0] B_in;

  modport master (
    output oRead_out_en,
    input  R_in, G_in, B_in
  );

  modport slave (
    input  oRead_out_en,
    output R_in, G_in, B_in
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running pixel/line counters,
// window decodes and registered active-low syncs.
module vga_timing_gen #(
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_START  = vga_timing_pkg::H_START,
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_TOTAL  = vga_timing_pkg::H_TOTAL,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_START  = vga_timing_pkg::V_START,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_TOTAL  = vga_timing_pkg::V_TOTAL
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Clock_en,
  output logic [vga_timing_pkg::H_W-1:0] H_Count,
  output logic [vga_timing_pkg::V_W-1:0] V_Count,
  output logic h_act,
  output logic v_act,
  output logic line_end,
  output logic frame_end,
  output logic rd_win_nxt,
  output logic hsync_n,
  output logic vsync_n
);
  import vga_timing_pkg::*;

  localparam logic [H_W-1:0] HS  = H_W'(H_SYNC);
  localparam logic [H_W-1:0] HA0 = H_W'(H_START);
  localparam logic [H_W-1:0] HA1 = H_W'(H_START + H_ACTIVE);
  localparam logic [H_W-1:0] HT1 = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] RD0 = H_W'(H_START - 1);
  localparam logic [H_W-1:0] RD1 = H_W'(H_START + H_ACTIVE - 2);
  localparam logic [V_W-1:0] VS  = V_W'(V_SYNC);
  localparam logic [V_W-1:0] VA0 = V_W'(V_START);
  localparam logic [V_W-1:0] VA1 = V_W'(V_START + V_ACTIVE);
  localparam logic [V_W-1:0] VT1 = V_W'(V_TOTAL - 1);

  logic [H_W-1:0] h_nxt;
  logic [V_W-1:0] v_nxt;
  logic           v_act_nxt;

  assign line_end  = (H_Count == HT1);
  assign frame_end = line_end && (V_Count == VT1);
  assign h_act     = (H_Count >= HA0) && (H_Count < HA1);
  assign v_act     = (V_Count >= VA0) && (V_Count < VA1);
  assign v_act_nxt = (v_nxt >= VA0) && (v_nxt < VA1);
  assign rd_win_nxt = (h_nxt >= RD0) && (h_nxt <= RD1)
                   && v_act_nxt;

  // counter values for the slot that follows this one
  always_comb begin
    h_nxt = H_Count + H_W'(1);
    v_nxt = V_Count;
    if (line_end) begin
      h_nxt = '0;
      v_nxt = frame_end ? '0 : V_Count + V_W'(1);
    end
  end

  // counters and syncs advance once per pixel slot
  always_ff @(posedge Clock) begin
    if (Reset) begin
      H_Count <= '0;
      V_Count <= '0;
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
    end else if (Clock_en) begin
      H_Count <= h_nxt;
      V_Count <= v_nxt;
      hsync_n <= !(H_Count < HS);
      vsync_n <= !(V_Count < VS);
    end
  end

endmodule

// File: rtl/vga_out_reader.sv
// vga_out_reader: display-side reader of the filter output
// line buffer; drives registered VGA pixels, sync, blank.
module vga_out_reader #(
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_START  = vga_timing_pkg::H_START,
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_TOTAL  = vga_timing_pkg::H_TOTAL,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_START  = vga_timing_pkg::V_START,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_TOTAL  = vga_timing_pkg::V_TOTAL
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Clock_en,
  input  logic Enable,
  output logic [vga_timing_pkg::H_W-1:0] H_Count,
  output logic [vga_timing_pkg::V_W-1:0] V_Count,
  vga_out_reader_if.master rd_bus,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic VGA_HSYNC_N,
  output logic VGA_VSYNC_N,
  output logic VGA_BLANK_N,
  output logic Frame_start,
  output logic Line_count_err
);
  import vga_timing_pkg::*;

  localparam logic [9:0] HA_CNT = 10'(H_ACTIVE);

  state_t     state;
  state_t     state_nxt;
  logic       run;
  logic       armed;
  logic       run_nxt;
  logic       h_act;
  logic       v_act;
  logic       act;
  logic       line_end;
  logic       frame_end;
  logic       rd_win_nxt;
  logic       rd_en;
  logic [9:0] line_cnt;
  logic [9:0] cnt_sum;

  vga_timing_gen #(
    .H_SYNC  (H_SYNC),
    .H_START (H_START),
    .H_ACTIVE(H_ACTIVE),
    .H_TOTAL (H_TOTAL),
    .V_SYNC  (V_SYNC),
    .V_START (V_START),
    .V_ACTIVE(V_ACTIVE),
    .V_TOTAL (V_TOTAL)
  ) u_tg (
    .Clock     (Clock),
    .Reset     (Reset),
    .Clock_en  (Clock_en),
    .H_Count   (H_Count),
    .V_Count   (V_Count),
    .h_act     (h_act),
    .v_act     (v_act),
    .line_end  (line_end),
    .frame_end (frame_end),
    .rd_win_nxt(rd_win_nxt),
    .hsync_n   (VGA_HSYNC_N),
    .vsync_n   (VGA_VSYNC_N)
  );

  assign act     = h_act && v_act;
  assign run_nxt = (state_nxt == RUN);
  assign cnt_sum = line_cnt + {9'b0, rd_en};
  assign rd_bus.oRead_out_en = rd_en;

  // state register
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state: Enable low parks the reader immediately
  always_comb begin
    state_nxt = state;
    if (!Enable) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nxt = WAIT_VS;
        WAIT_VS: if (Clock_en && frame_end)
                   state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // state decode
  always_comb begin
    run   = 1'b0;
    armed = 1'b0;
    unique case (1'b1)
      state == RUN: begin
        run   = 1'b1;
        armed = 1'b1;
      end
      state == WAIT_VS: armed = 1'b1;
      default: ;
    endcase
  end

  // one-Clock pulse on the frame wrap while armed
  always_ff @(posedge Clock) begin
    if (Reset) Frame_start <= 1'b0;
    else Frame_start <= Clock_en && Enable
                     && armed && frame_end;
  end

  // read request runs one slot ahead of display
  always_ff @(posedge Clock) begin
    if (Reset)         rd_en <= 1'b0;
    else if (!Enable)  rd_en <= 1'b0;
    else if (Clock_en) rd_en <= rd_win_nxt && run_nxt;
  end

  // capture returned pixel; blank outside window or RUN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_BLANK_N <= 1'b0;
    end else if (Clock_en) begin
      VGA_R       <= (act && run) ? rd_bus.R_in : '0;
      VGA_G       <= (act && run) ? rd_bus.G_in : '0;
      VGA_B       <= (act && run) ? rd_bus.B_in : '0;
      VGA_BLANK_N <= act && run;
    end
  end

  // per-line read count with sticky mismatch flag
  always_ff @(posedge Clock) begin
    if (Reset) begin
      line_cnt       <= '0;
      Line_count_err <= 1'b0;
    end else if (Clock_en) begin
      line_cnt <= line_end ? '0 : cnt_sum;
      if (line_end && v_act && run && Enable
          && cnt_sum != HA_CNT)
        Line_count_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_out_reader.sv
// tb_vga_out_reader: random Clock_en/Enable stimulus on a
// shrunken raster, checked against a slot-level model.
module tb_vga_out_reader;
  localparam int HS  = 4;
  localparam int HST = 8;
  localparam int HA  = 16;
  localparam int HT  = 30;
  localparam int VS  = 2;
  localparam int VST = 3;
  localparam int VA  = 5;
  localparam int VT  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;
  logic en  = 1'b0;
  logic [10:0] H_Count;
  logic [9:0]  V_Count;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic VGA_HSYNC_N, VGA_VSYNC_N, VGA_BLANK_N;
  logic Frame_start, Line_count_err;

  vga_out_reader_if bus();

  vga_out_reader #(
    .H_SYNC(HS), .H_START(HST), .H_ACTIVE(HA),
    .H_TOTAL(HT), .V_SYNC(VS), .V_START(VST),
    .V_ACTIVE(VA), .V_TOTAL(VT)
  ) dut (
    .Clock(clk), .Reset(rst), .Clock_en(ce),
    .Enable(en), .H_Count(H_Count),
    .V_Count(V_Count), .rd_bus(bus),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HSYNC_N(VGA_HSYNC_N),
    .VGA_VSYNC_N(VGA_VSYNC_N),
    .VGA_BLANK_N(VGA_BLANK_N),
    .Frame_start(Frame_start),
    .Line_count_err(Line_count_err)
  );

  always #5 clk = ~clk;

  int ce_mode = 0;
  always @(posedge clk) begin
    #2;
    if (ce_mode == 0) ce = ~ce;
    else ce = ($urandom_range(0, 2) != 0);
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input int a,
                     input int e);
    nvec++;
    if (a != e) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d (t=%0t)",
               nm, a, e, $time);
    end
  endtask

  function automatic bit vin(input int vv);
    return vv >= VST && vv < VST + VA;
  endfunction

  function automatic bit hin(input int hh);
    return hh >= HST && hh < HST + HA;
  endfunction

  // model state: raster position, reader mode, outputs
  int h = 0, v = 0, st = 0, lc = 0, idx = 0, lreads = 0;
  bit e_rd, e_hs, e_vs, e_bl, e_fs, e_err;
  logic [7:0] e_r, e_g, e_b, nr, ng, nb;
  bit glitch = 0, skip = 0, lclean = 0;
  bit s_rst, s_ce, s_en, s_rd, s_gl, wrap, lend, run;
  logic [7:0] s_r, s_g, s_b;

  always @(posedge clk) begin
    s_rst = rst; s_ce = ce; s_en = en; s_gl = glitch;
    s_rd = bus.oRead_out_en;
    s_r = bus.R_in; s_g = bus.G_in; s_b = bus.B_in;
    if (s_rst) begin
      h = 0; v = 0; st = 0; lc = 0; idx = 0;
      lreads = 0; lclean = 0;
      e_rd = 0; e_r = 0; e_g = 0; e_b = 0;
      e_hs = 1; e_vs = 1; e_bl = 0; e_fs = 0; e_err = 0;
    end else begin
      e_fs = 0;
      lend = (h == HT - 1);
      wrap = lend && (v == VT - 1);
      run  = (st == 2);
      if (s_ce) begin
        e_bl = hin(h) && vin(v) && run;
        e_r = e_bl ? s_r : 8'h00;
        e_g = e_bl ? s_g : 8'h00;
        e_b = e_bl ? s_b : 8'h00;
        e_hs = (h >= HS);
        e_vs = (v >= VS);
        if (e_rd && !s_gl) lc++;
        if (lend && vin(v) && run && s_en && lc != HA)
          e_err = 1;
        if (lend) lc = 0;
        e_fs = (st != 0) && s_en && wrap;
        if (s_rd) begin
          nr = idx[7:0];
          ng = 8'($urandom);
          nb = 8'($urandom);
          idx++;
          lreads++;
        end
        if (lend) begin
          if (vin(v) && lclean)
            chk("reads_per_line", lreads, HA);
          idx = 0; lreads = 0; lclean = 1;
        end
        if (lend) v = (v == VT - 1) ? 0 : v + 1;
        h = lend ? 0 : h + 1;
      end
      if (!s_en) st = 0;
      else if (st == 0) st = 1;
      else if (st == 1 && s_ce && wrap) st = 2;
      if (!s_en) e_rd = 0;
      else if (s_ce)
        e_rd = (st == 2) && vin(v)
            && h >= HST - 1 && h <= HST + HA - 2;
      if (st != 2 || !s_en || s_gl || skip) lclean = 0;
    end
    #1;
    chk("H_Count", int'(H_Count), h);
    chk("V_Count", int'(V_Count), v);
    if (!skip) chk("rd_en", int'(bus.oRead_out_en), e_rd);
    chk("VGA_R", int'(VGA_R), int'(e_r));
    chk("VGA_G", int'(VGA_G), int'(e_g));
    chk("VGA_B", int'(VGA_B), int'(e_b));
    chk("HSYNC_N", int'(VGA_HSYNC_N), e_hs);
    chk("VSYNC_N", int'(VGA_VSYNC_N), e_vs);
    chk("BLANK_N", int'(VGA_BLANK_N), e_bl);
    chk("Frame_start", int'(Frame_start), e_fs);
    chk("Line_err", int'(Line_count_err), e_err);
    if (e_bl && lclean)
      chk("ramp", int'(VGA_R), int'(H_Count) - HST - 1);
    bus.R_in = nr; bus.G_in = ng; bus.B_in = nb;
  end

  task automatic wait_hv(input int hh, input int vv,
                         input bit need_run);
    int n = 0;
    while (!(int'(H_Count) == hh && int'(V_Count) == vv
             && (!need_run || st == 2))) begin
      @(negedge clk);
      n++;
      if (n > 6000) begin
        nvec++; nerr++;
        $display("FAIL wait_hv: got timeout want h=%0d v=%0d",
                 hh, vv);
        return;
      end
    end
  endtask

  task automatic wait_ce_edge();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!ce && n < 100);
  endtask

  task automatic reset_literals();
    chk("rst_H", int'(H_Count), 0);
    chk("rst_V", int'(V_Count), 0);
    chk("rst_rd", int'(bus.oRead_out_en), 0);
    chk("rst_R", int'(VGA_R), 0);
    chk("rst_HS", int'(VGA_HSYNC_N), 1);
    chk("rst_VS", int'(VGA_VSYNC_N), 1);
    chk("rst_BL", int'(VGA_BLANK_N), 0);
    chk("rst_FS", int'(Frame_start), 0);
    chk("rst_ERR", int'(Line_count_err), 0);
  endtask

  initial begin
    nr = 0; ng = 0; nb = 0;
    bus.R_in = 0; bus.G_in = 0; bus.B_in = 0;
    repeat (4) @(negedge clk);
    reset_literals();
    rst = 0;
    repeat (1300) @(negedge clk);
    ce_mode = 1;
    wait_hv(5, 4, 0);
    en = 1;
    repeat (2000) @(negedge clk);
    wait_hv(12, VST + 1, 1);
    en = 0;
    repeat (80) @(negedge clk);
    en = 1;
    repeat (1500) @(negedge clk);
    wait_hv(HST + 2, VST + 1, 1);
    force dut.rd_en = 1'b0;
    glitch = 1; skip = 1;
    wait_ce_edge();
    #2 release dut.rd_en;
    glitch = 0;
    wait_ce_edge();
    #3 skip = 0;
    repeat (1500) @(negedge clk);
    wait_hv(10, VST + 1, 1);
    chk("err_sticky", int'(Line_count_err), 1);
    rst = 1;
    @(posedge clk);
    #2 reset_literals();
    @(negedge clk);
    rst = 0;
    repeat (900) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/vga_out_reader.md
Name: vga_out_reader

Overview:
- Display-side consumer of the filter pipe's output line buffer.
- Generates the pixel timing counters that the filter pipe consumes, and the per-pixel read request for the output buffer.
- Captures the returned RGB and drives registered VGA RGB, sync and blank outputs.
- Adds a frame-start pulse and a sticky per-line read-count check for debug.

Parameters:
- H_SYNC, 96, horizontal sync width in pixel slots
- H_START, 216, H_Count value of first active pixel
- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 1040, pixel slots per line
- V_SYNC, 2, vertical sync width in lines
- V_START, 35, V_Count value of first active line
- V_ACTIVE, 480, active lines per frame
- V_TOTAL, 525, lines per frame

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- Clock_en  in  1  pixel-slot enable; one slot = Clock cycles between Clock_en pulses
- Enable  in  1  block enable
- H_Count  out  11  horizontal slot counter
- V_Count  out  10  line counter
- oRead_out_en  out  1  read request to output buffer; one pixel per slot while high
- R_in, G_in, B_in  in  8 each  buffer read data; valid at the slot after the request
- VGA_R, VGA_G, VGA_B  out  8 each  registered pixel data
- VGA_HSYNC_N, VGA_VSYNC_N, VGA_BLANK_N  out  1 each  active-low sync/blank
- Frame_start  out  1  one-Clock pulse at start of each RUN frame
- Line_count_err  out  1  sticky error flag; a line issued a read count other than H_ACTIVE

Behaviour:
- All state advances only on Clock & Clock_en, except Reset/Enable handling and the Frame_start pulse.
- Reset (synchronous, highest priority) sets:
  - counters to 0
  - state to IDLE
  - oRead_out_en 0, RGB 0
  - HSYNC_N/VSYNC_N 1, BLANK_N 0
  - Frame_start 0, Line_count_err 0
- Counters:
  - H_Count wraps H_TOTAL-1 -> 0; V_Count increments on that wrap and wraps V_TOTAL-1 -> 0.
  - Counters free-run whenever Reset is low, regardless of Enable, so the monitor stays synced.
- Window definitions:
  - h_act = H_START <= H_Count < H_START+H_ACTIVE
  - v_act = V_START <= V_Count < V_START+V_ACTIVE
  - hs = H_Count < H_SYNC
  - vs = V_Count < V_SYNC
- FSM IDLE / WAIT_VS / RUN:
  - IDLE: Enable=1 -> WAIT_VS.
  - WAIT_VS: Clock_en and H and V both wrapping to 0 -> RUN; Frame_start pulses for exactly one Clock on that edge.
  - RUN: continues while Enable=1; the same wrap in RUN also pulses Frame_start.
  - Enable=0 in any state -> IDLE on the next Clock; oRead_out_en drops the same edge.
- Read request:
  - oRead_out_en is registered on Clock_en.
  - High for the slots H_Count in [H_START-1, H_START+H_ACTIVE-2], only when v_act and state=RUN.
  - Exactly H_ACTIVE slots per active line, one slot ahead of pixel display to absorb the buffer's one-slot read latency.
  - Held constant across all Clock cycles of a slot.
- Data path:
  - At the Clock_en ending slot H_START+n (n=0..H_ACTIVE-1), R/G/B_in is captured into VGA_R/G/B.
  - Pixel n is therefore visible during slot H_START+n+1.
  - Outside h_act & v_act, or when not RUN, VGA_R/G/B are loaded with 0.
- Sync/blank:
  - Registered from hs, vs and (h_act & v_act) at the same edge.
  - Total latency from counter value to pin is one slot, aligned with the RGB outputs.
  - Sync outputs run in all states.
  - BLANK_N=1 only when h_act & v_act & RUN.
- Line check:
  - A 10-bit counter clears at H_Count=0 and counts Clock_en slots with oRead_out_en=1.
  - At H_Count=H_TOTAL-1 of an active line in RUN, a value not equal to H_ACTIVE sets Line_count_err.
  - Line_count_err clears only on Reset.
- Enable dropping mid-line: reads stop immediately, no error is flagged for that line, and RGB is forced to 0 from the next slot.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the timing constants above
  - the state enum (IDLE, WAIT_VS, RUN)
  - width localparams H_W=11, V_W=10
- One natural sub-module: vga_timing_gen, containing the counters, window decodes and registered sync. The FSM, read request and data capture stay in the top.

Test Plan:
- Reset with Clock_en toggling every 2nd Clock, Enable=0 -> counters run, HSYNC_N low for 96 slots per 1040, VSYNC_N low 2 lines per 525, oRead_out_en never high, BLANK_N=0, RGB=0.
- Enable=1 mid-frame -> no reads until V/H wrap; Frame_start pulses once at wrap; first read at H_Count=215, V_Count=35.
- Ramp model (R_in = previous read index mod 256, one-slot latency) -> VGA_R=0 at slot 217, 1 at 218 ... 255 at 472, 0 at 473; BLANK_N high for slots 217..856 only; exactly 640 reads per line.
- Enable deasserted at H_Count=500, V_Count=100 -> oRead_out_en 0 next Clock, RGB 0 from next slot, Line_count_err stays 0, no Frame_start until re-enabled and wrapped.
- Force a bench glitch suppressing one read slot (checker override) -> Line_count_err=1 at end of that line, still 1 after following good frames.
- Reset asserted mid-RUN at V_Count=200 -> next Clock: H/V=0, state IDLE, all outputs at reset values.
